// File: rtl/log_rs.sv
// log_rs: reservation station that holds decoded logical ops until their operands arrive, then issues them to the logical unit
package log_pkg;
  typedef enum logic [2:0] {
    LOG_AND, LOG_OR, LOG_XOR, LOG_NAND, LOG_NOR, LOG_EQV, LOG_ANDC, LOG_ORC
  } log_op_e;
  typedef struct packed {
    log_op_e op;
    logic    rc;
    logic    oe;
  } log_decode_t;
endpackage

module log_rs
  import log_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_COUNT    = 4,
  parameter int RS_OFFSET   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   take_valid,
  output logic                   take_ready,
  output logic [RS_ID_WIDTH-1:0] id_taken,
  input  logic                   op1_valid_in,
  input  logic                   op2_valid_in,
  input  logic                   so_valid_in,
  input  logic [31:0]            op1_in,
  input  logic [31:0]            op2_in,
  input  logic                   so_in,
  input  logic [RS_ID_WIDTH-1:0] op1_rs_id_in,
  input  logic [RS_ID_WIDTH-1:0] op2_rs_id_in,
  input  logic [RS_ID_WIDTH-1:0] so_rs_id_in,
  input  log_decode_t            control_in,
  input  logic [4:0]             result_reg_addr_in,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  input  logic                   cdb_so,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [4:0]             result_reg_addr_out,
  output logic [31:0]            op1_out,
  output logic [31:0]            op2_out,
  output logic                   so_out,
  output log_decode_t            control_out
);
  localparam int IW = (RS_COUNT > 1) ? $clog2(RS_COUNT) : 1;
  typedef logic [RS_ID_WIDTH-1:0] tag_t;
  typedef struct packed {
    logic        busy;
    logic        op1_v;
    logic [31:0] op1;
    tag_t        op1_tag;
    logic        op2_v;
    logic [31:0] op2;
    tag_t        op2_tag;
    logic        so_v;
    logic        so;
    tag_t        so_tag;
    log_decode_t control;
    logic [4:0]  rd;
  } entry_t;
  entry_t ent_q [RS_COUNT];
  entry_t ent_d [RS_COUNT];
  entry_t alloc;
  logic [RS_COUNT-1:0] elig;
  logic free_found;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] iss_idx;
  // lowest free slot for allocation and lowest operand-complete slot for issue, both from registered state
  always_comb begin
    free_found = 1'b0;
    free_idx = '0;
    iss_idx = '0;
    elig = '0;
    for (int i = RS_COUNT - 1; i >= 0; i--) begin
      elig[i] = ent_q[i].busy & ent_q[i].op1_v & ent_q[i].op2_v & ent_q[i].so_v;
      free_found = free_found | ~ent_q[i].busy;
      free_idx = ent_q[i].busy ? free_idx : IW'(i);
      iss_idx = elig[i] ? IW'(i) : iss_idx;
    end
  end
  assign take_ready = free_found;
  assign id_taken = free_found ? tag_t'(RS_OFFSET) + tag_t'(free_idx) : '0;
  // nothing issues while reset is asserted, even though the entries still look busy
  assign issue_valid = (|elig) & ~rst;
  assign rs_id_out = issue_valid ? tag_t'(RS_OFFSET) + tag_t'(iss_idx) : '0;
  assign result_reg_addr_out = issue_valid ? ent_q[iss_idx].rd : '0;
  assign op1_out = issue_valid ? ent_q[iss_idx].op1 : '0;
  assign op2_out = issue_valid ? ent_q[iss_idx].op2 : '0;
  assign so_out = issue_valid & ent_q[iss_idx].so;
  assign control_out = issue_valid ? ent_q[iss_idx].control : '0;
  // new entry image: present operands are taken directly, else forwarded from a same-cycle CDB hit, else left waiting on the tag
  always_comb begin
    alloc = '0;
    alloc.busy = 1'b1;
    alloc.op1_v = op1_valid_in | (cdb_valid & (cdb_rs_id == op1_rs_id_in));
    alloc.op1 = op1_valid_in ? op1_in : alloc.op1_v ? cdb_result : '0;
    alloc.op1_tag = op1_rs_id_in;
    alloc.op2_v = op2_valid_in | (cdb_valid & (cdb_rs_id == op2_rs_id_in));
    alloc.op2 = op2_valid_in ? op2_in : alloc.op2_v ? cdb_result : '0;
    alloc.op2_tag = op2_rs_id_in;
    alloc.so_v = so_valid_in | (cdb_valid & (cdb_rs_id == so_rs_id_in));
    alloc.so = so_valid_in ? so_in : alloc.so_v & cdb_so;
    alloc.so_tag = so_rs_id_in;
    alloc.control = control_in;
    alloc.rd = result_reg_addr_in;
  end
  // per-entry update: CDB snoop wakes waiting operands, a handshake frees the issued slot, allocation fills the lowest free slot
  always_comb begin
    for (int i = 0; i < RS_COUNT; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy && cdb_valid) begin
        if (!ent_q[i].op1_v && ent_q[i].op1_tag == cdb_rs_id) begin
          ent_d[i].op1_v = 1'b1;
          ent_d[i].op1 = cdb_result;
        end
        if (!ent_q[i].op2_v && ent_q[i].op2_tag == cdb_rs_id) begin
          ent_d[i].op2_v = 1'b1;
          ent_d[i].op2 = cdb_result;
        end
        if (!ent_q[i].so_v && ent_q[i].so_tag == cdb_rs_id) begin
          ent_d[i].so_v = 1'b1;
          ent_d[i].so = cdb_so;
        end
      end
      if (issue_valid && issue_ready && iss_idx == IW'(i)) ent_d[i].busy = 1'b0;
      if (take_valid && free_found && free_idx == IW'(i)) ent_d[i] = alloc;
    end
  end
  // entry state register; reset discards every entry
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_COUNT; i++) ent_q[i] <= rst ? '0 : ent_d[i];
  end
endmodule

// File: tb/tb_log_rs.sv
// tb_log_rs: directed self-checking bench for the logical-unit reservation station
module tb_log_rs;
  import log_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic take_valid, take_ready;
  logic [4:0] id_taken;
  logic op1_valid_in, op2_valid_in, so_valid_in;
  logic [31:0] op1_in, op2_in;
  logic so_in;
  logic [4:0] op1_rs_id_in, op2_rs_id_in, so_rs_id_in;
  log_decode_t control_in;
  logic [4:0] result_reg_addr_in;
  logic cdb_valid;
  logic [4:0] cdb_rs_id;
  logic [31:0] cdb_result;
  logic cdb_so;
  logic issue_valid, issue_ready;
  logic [4:0] rs_id_out, result_reg_addr_out;
  logic [31:0] op1_out, op2_out;
  logic so_out;
  log_decode_t control_out;
  int n_cmp = 0;
  int n_err = 0;

  log_rs #(.RS_ID_WIDTH(5), .RS_COUNT(4), .RS_OFFSET(0)) dut (
    .clk(clk), .rst(rst), .take_valid(take_valid), .take_ready(take_ready), .id_taken(id_taken),
    .op1_valid_in(op1_valid_in), .op2_valid_in(op2_valid_in), .so_valid_in(so_valid_in),
    .op1_in(op1_in), .op2_in(op2_in), .so_in(so_in),
    .op1_rs_id_in(op1_rs_id_in), .op2_rs_id_in(op2_rs_id_in), .so_rs_id_in(so_rs_id_in),
    .control_in(control_in), .result_reg_addr_in(result_reg_addr_in),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result), .cdb_so(cdb_so),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .rs_id_out(rs_id_out),
    .result_reg_addr_out(result_reg_addr_out), .op1_out(op1_out), .op2_out(op2_out),
    .so_out(so_out), .control_out(control_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    take_valid = 1'b0;
    op1_valid_in = 1'b0;
    op2_valid_in = 1'b0;
    so_valid_in = 1'b0;
    op1_in = '0;
    op2_in = '0;
    so_in = 1'b0;
    op1_rs_id_in = '0;
    op2_rs_id_in = '0;
    so_rs_id_in = '0;
    control_in = '0;
    result_reg_addr_in = '0;
    cdb_valid = 1'b0;
    cdb_rs_id = '0;
    cdb_result = '0;
    cdb_so = 1'b0;
  endtask

  task automatic disp(input logic v1, input logic [31:0] o1, input logic [4:0] t1,
                      input logic v2, input logic [31:0] o2, input logic [4:0] t2,
                      input logic vs, input logic s, input logic [4:0] ts,
                      input log_op_e op, input logic [4:0] rd);
    take_valid = 1'b1;
    op1_valid_in = v1;
    op1_in = o1;
    op1_rs_id_in = t1;
    op2_valid_in = v2;
    op2_in = o2;
    op2_rs_id_in = t2;
    so_valid_in = vs;
    so_in = s;
    so_rs_id_in = ts;
    control_in = '{op: op, rc: 1'b0, oe: 1'b0};
    result_reg_addr_in = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    issue_ready = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({issue_valid, rs_id_out, result_reg_addr_out, op1_out, op2_out, so_out, control_out} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got iv=%b id=%h rd=%h op1=%h op2=%h so=%b ctl=%h, expected all zero",
               issue_valid, rs_id_out, result_reg_addr_out, op1_out, op2_out, so_out, control_out);
    end
    n_cmp++;
    if ({take_ready, id_taken} !== {1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL reset_take: got ready=%b id=%0d, expected ready=1 id=0", take_ready, id_taken);
    end
  endtask

  task automatic test_basic();
    issue_ready = 1'b1;
    disp(1'b1, 32'h0000FFFF, 5'd0, 1'b1, 32'h00FF00FF, 5'd0, 1'b1, 1'b0, 5'd0, LOG_AND, 5'd3);
    #1;
    n_cmp++;
    if ({take_ready, id_taken, issue_valid} !== {1'b1, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL basic_alloc: got ready=%b id=%0d iv=%b, expected ready=1 id=0 iv=0", take_ready, id_taken, issue_valid);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if ({issue_valid, rs_id_out, op1_out, op2_out, so_out, result_reg_addr_out, control_out.op} !==
        {1'b1, 5'd0, 32'h0000FFFF, 32'h00FF00FF, 1'b0, 5'd3, LOG_AND}) begin
      n_err++;
      $display("FAIL basic_issue: got iv=%b id=%0d op1=%h op2=%h so=%b rd=%0d op=%0d, expected 1 0 0000ffff 00ff00ff 0 3 0",
               issue_valid, rs_id_out, op1_out, op2_out, so_out, result_reg_addr_out, control_out.op);
    end
    step();
    n_cmp++;
    if ({issue_valid, take_ready, id_taken} !== {1'b0, 1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL basic_drain: got iv=%b ready=%b id=%0d, expected iv=0 ready=1 id=0", issue_valid, take_ready, id_taken);
    end
  endtask

  task automatic test_cdb_wake();
    issue_ready = 1'b1;
    disp(1'b1, 32'h0000000A, 5'd0, 1'b0, 32'h0, 5'd9, 1'b1, 1'b1, 5'd0, LOG_XOR, 5'd4);
    step();
    idle();
    cdb_valid = 1'b1;
    cdb_rs_id = 5'd8;
    cdb_result = 32'hFFFFFFFF;
    #1;
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wake_waiting: got iv=%b, expected 0", issue_valid);
    end
    step();
    cdb_rs_id = 5'd9;
    cdb_result = 32'h12345678;
    #1;
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wake_wrong_tag: got iv=%b, expected 0 after tag 8 broadcast and during tag 9 broadcast", issue_valid);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if ({issue_valid, rs_id_out, op1_out, op2_out, so_out, result_reg_addr_out} !==
        {1'b1, 5'd0, 32'h0000000A, 32'h12345678, 1'b1, 5'd4}) begin
      n_err++;
      $display("FAIL wake_issue: got iv=%b id=%0d op1=%h op2=%h so=%b rd=%0d, expected 1 0 0000000a 12345678 1 4",
               issue_valid, rs_id_out, op1_out, op2_out, so_out, result_reg_addr_out);
    end
    step();
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wake_drain: got iv=%b, expected 0", issue_valid);
    end
  endtask

  task automatic test_forward();
    issue_ready = 1'b1;
    disp(1'b0, 32'h0, 5'd7, 1'b1, 32'h00000005, 5'd0, 1'b1, 1'b0, 5'd0, LOG_OR, 5'd9);
    cdb_valid = 1'b1;
    cdb_rs_id = 5'd7;
    cdb_result = 32'hDEADBEEF;
    step();
    idle();
    #1;
    n_cmp++;
    if ({issue_valid, rs_id_out, op1_out, op2_out, result_reg_addr_out} !==
        {1'b1, 5'd0, 32'hDEADBEEF, 32'h00000005, 5'd9}) begin
      n_err++;
      $display("FAIL forward_issue: got iv=%b id=%0d op1=%h op2=%h rd=%0d, expected 1 0 deadbeef 00000005 9",
               issue_valid, rs_id_out, op1_out, op2_out, result_reg_addr_out);
    end
    step();
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL forward_drain: got iv=%b, expected 0", issue_valid);
    end
  endtask

  task automatic test_full();
    logic [31:0] exp_op1 [4];
    exp_op1[0] = 32'h55;
    exp_op1[1] = 32'h2;
    exp_op1[2] = 32'h3;
    exp_op1[3] = 32'h4;
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(1'b1, 32'(i + 1), 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 1'b0, 5'd0, LOG_OR, 5'(i + 1));
      #1;
      n_cmp++;
      if ({take_ready, id_taken} !== {1'b1, 5'(i)}) begin
        n_err++;
        $display("FAIL full_fill_%0d: got ready=%b id=%0d, expected ready=1 id=%0d", i, take_ready, id_taken, i);
      end
      step();
    end
    disp(1'b1, 32'h99, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 1'b0, 5'd0, LOG_OR, 5'd31);
    #1;
    n_cmp++;
    if ({take_ready, id_taken, issue_valid, rs_id_out, op1_out} !== {1'b0, 5'd0, 1'b1, 5'd0, 32'h1}) begin
      n_err++;
      $display("FAIL full_blocked: got ready=%b id=%0d iv=%b rsid=%0d op1=%h, expected 0 0 1 0 00000001",
               take_ready, id_taken, issue_valid, rs_id_out, op1_out);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if ({take_ready, issue_valid, rs_id_out, op1_out} !== {1'b0, 1'b1, 5'd0, 32'h1}) begin
      n_err++;
      $display("FAIL full_stall: got ready=%b iv=%b rsid=%0d op1=%h, expected 0 1 0 00000001",
               take_ready, issue_valid, rs_id_out, op1_out);
    end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    #1;
    n_cmp++;
    if ({take_ready, id_taken, rs_id_out, op1_out} !== {1'b1, 5'd0, 5'd1, 32'h2}) begin
      n_err++;
      $display("FAIL full_free: got ready=%b id=%0d rsid=%0d op1=%h, expected 1 0 1 00000002",
               take_ready, id_taken, rs_id_out, op1_out);
    end
    disp(1'b1, 32'h55, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 1'b0, 5'd0, LOG_NOR, 5'd7);
    step();
    idle();
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if ({issue_valid, rs_id_out, op1_out} !== {1'b1, 5'(k), exp_op1[k]}) begin
        n_err++;
        $display("FAIL full_drain_%0d: got iv=%b rsid=%0d op1=%h, expected 1 %0d %h",
                 k, issue_valid, rs_id_out, op1_out, k, exp_op1[k]);
      end
      step();
    end
    n_cmp++;
    if ({issue_valid, take_ready} !== {1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL full_empty: got iv=%b ready=%b, expected 0 1", issue_valid, take_ready);
    end
  endtask

  task automatic test_multi_wake();
    issue_ready = 1'b0;
    disp(1'b0, 32'h0, 5'd5, 1'b1, 32'h1, 5'd0, 1'b1, 1'b0, 5'd0, LOG_AND, 5'd10);
    step();
    disp(1'b1, 32'h2, 5'd0, 1'b0, 32'h0, 5'd6, 1'b1, 1'b0, 5'd0, LOG_AND, 5'd11);
    step();
    disp(1'b1, 32'h3, 5'd0, 1'b1, 32'h3, 5'd0, 1'b0, 1'b0, 5'd5, LOG_AND, 5'd12);
    step();
    idle();
    cdb_valid = 1'b1;
    cdb_rs_id = 5'd5;
    cdb_result = 32'h0BADF00D;
    cdb_so = 1'b1;
    #1;
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL multi_waiting: got iv=%b, expected 0", issue_valid);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if ({issue_valid, rs_id_out, op1_out, result_reg_addr_out} !== {1'b1, 5'd0, 32'h0BADF00D, 5'd10}) begin
      n_err++;
      $display("FAIL multi_first: got iv=%b rsid=%0d op1=%h rd=%0d, expected 1 0 0badf00d 10",
               issue_valid, rs_id_out, op1_out, result_reg_addr_out);
    end
    issue_ready = 1'b1;
    step();
    n_cmp++;
    if ({issue_valid, rs_id_out, so_out, result_reg_addr_out} !== {1'b1, 5'd2, 1'b1, 5'd12}) begin
      n_err++;
      $display("FAIL multi_second: got iv=%b rsid=%0d so=%b rd=%0d, expected 1 2 1 12",
               issue_valid, rs_id_out, so_out, result_reg_addr_out);
    end
    step();
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL multi_gap: got iv=%b, expected 0 with entry 1 still waiting", issue_valid);
    end
    cdb_valid = 1'b1;
    cdb_rs_id = 5'd6;
    cdb_result = 32'h66;
    step();
    idle();
    #1;
    n_cmp++;
    if ({issue_valid, rs_id_out, op2_out} !== {1'b1, 5'd1, 32'h66}) begin
      n_err++;
      $display("FAIL multi_third: got iv=%b rsid=%0d op2=%h, expected 1 1 00000066", issue_valid, rs_id_out, op2_out);
    end
    step();
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL multi_drain: got iv=%b, expected 0", issue_valid);
    end
  endtask

  task automatic test_reset_mid();
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(1'b1, 32'hA0 + 32'(i), 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 1'b0, 5'd0, LOG_EQV, 5'd20);
      step();
    end
    idle();
    #1;
    n_cmp++;
    if ({issue_valid, take_ready} !== {1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL rstmid_before: got iv=%b ready=%b, expected 1 1", issue_valid, take_ready);
    end
    rst = 1'b1;
    issue_ready = 1'b1;
    #1;
    n_cmp++;
    if (issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_cycle: got iv=%b, expected 0 during reset", issue_valid);
    end
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({issue_valid, take_ready, id_taken} !== {1'b0, 1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL rstmid_after: got iv=%b ready=%b id=%0d, expected 0 1 0", issue_valid, take_ready, id_taken);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (issue_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_stale_%0d: got iv=%b rsid=%0d op1=%h, expected iv=0", k, issue_valid, rs_id_out, op1_out);
      end
    end
    disp(1'b1, 32'h77, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 1'b0, 5'd0, LOG_ANDC, 5'd21);
    step();
    idle();
    #1;
    n_cmp++;
    if ({issue_valid, rs_id_out, op1_out, result_reg_addr_out} !== {1'b1, 5'd0, 32'h77, 5'd21}) begin
      n_err++;
      $display("FAIL rstmid_reuse: got iv=%b rsid=%0d op1=%h rd=%0d, expected 1 0 00000077 21",
               issue_valid, rs_id_out, op1_out, result_reg_addr_out);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_wake();
    test_forward();
    test_full();
    test_multi_wake();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
